// File: rtl/vram_wr_sched_pkg.sv
// vram_wr_sched_pkg: shared canvas constants and FSM state type for the VRAM
// write scheduler. The CLEAR state exists only when VRAM_CLEAR_EN is defined.
package vram_wr_sched_pkg;

  localparam int RGB_W      = 12;
  localparam int CANVAS_H   = 200;
  localparam int CANVAS_V   = 150;
  localparam int CANVAS_PIX = CANVAS_H * CANVAS_V;
  localparam int VRAM_DW    = 15;

  localparam logic [RGB_W-1:0] BG_DEFAULT = 12'h000;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;
`else
  typedef enum logic {
    S_IDLE = 1'b0
  } state_t;
`endif

endpackage

// File: rtl/vram_wr_sched_if.sv
// vram_wr_sched_if: client request/grant bundle plus the VRAM write port.
// The master side is the clients + VRAM, the slave side is the scheduler.
interface vram_wr_sched_if
  import vram_wr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = VRAM_DW
);

  logic [NREQ-1:0]       req;
  logic [NREQ*DW-1:0]    req_addr;
  logic [NREQ*RGB_W-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  we;
  logic [DW-1:0]         waddr;
  logic [RGB_W-1:0]      wdata;

  modport master (
    output req, req_addr, req_data,
    input  gnt, we, waddr, wdata
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, we, waddr, wdata
  );

endinterface

// File: rtl/vram_wr_sched_rr_arbiter.sv
// vram_wr_sched_rr_arbiter: combinational rotating-priority picker. Searches
// the request vector starting at the round-robin pointer, wrapping modulo NREQ,
// and returns the one-hot winner and its index.
module vram_wr_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  // First asserted request at or after the pointer wins
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] j;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    sum     = '0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, i_rr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      j = sum[PW-1:0];
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
  end

endmodule

// File: rtl/vram_wr_sched.sv
// vram_wr_sched: sole writer of the canvas VRAM. Round-robin arbitration among
// NREQ drawing clients, one write per cycle, with an address range check.
// Optional hardware canvas clear at vertical blank: define VRAM_CLEAR_EN.
module vram_wr_sched
  import vram_wr_sched_pkg::*;
#(
  parameter int               DW       = VRAM_DW,
  parameter int               H_LEN    = CANVAS_H,
  parameter int               V_LEN    = CANVAS_V,
  parameter int               NREQ     = 4,
  parameter logic [RGB_W-1:0] BG_COLOR = BG_DEFAULT
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           vblank,
  vram_wr_sched_if.slave bus,
  output logic           busy,
  output logic           oob_err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NPIX = H_LEN * V_LEN;

  state_t           r_state;
  logic [PW-1:0]    r_rr;
  logic [NREQ-1:0]  r_gnt;
  logic             r_we;
  logic [DW-1:0]    r_waddr;
  logic [RGB_W-1:0] r_wdata;
  logic             r_oob;

  logic [NREQ-1:0]  w_req_elig;
  logic [NREQ-1:0]  w_arb_gnt;
  logic [PW-1:0]    w_arb_idx;
  logic             w_arb_valid;
  logic [DW-1:0]    w_sel_addr;
  logic [RGB_W-1:0] w_sel_data;
  logic             w_sel_oob;
  logic [PW-1:0]    w_rr_next;
  logic             w_do_grant;

  // A client just granted still holds req this cycle; hide it so it is not granted twice
  assign w_req_elig = bus.req & ~r_gnt;

  vram_wr_sched_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req   (w_req_elig),
    .i_rr    (r_rr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_sel_addr = bus.req_addr[int'(w_arb_idx)*DW +: DW];
  assign w_sel_data = bus.req_data[int'(w_arb_idx)*RGB_W +: RGB_W];
  assign w_sel_oob  = (32'(w_sel_addr) >= NPIX);
  assign w_rr_next  = (int'(w_arb_idx) == NREQ - 1) ? '0 : w_arb_idx + 1'b1;

`ifdef VRAM_CLEAR_EN
  logic          r_busy;
  logic [DW-1:0] r_clr_left;
  logic          w_clr_done;

  assign w_clr_done = (r_clr_left == '0);
  // vblank in IDLE wins over a pending grant; the last clear cycle may already grant
  assign w_do_grant = w_arb_valid &&
                      (((r_state == S_IDLE) && !vblank) ||
                       ((r_state == S_CLEAR) && w_clr_done));
  assign busy       = r_busy;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = vblank ^ (|BG_COLOR);
  assign w_do_grant   = w_arb_valid;
  assign busy         = 1'b0;
`endif

  // FSM: clear sequencing, arbitration grants and the registered write port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_gnt      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_oob      <= 1'b0;
`ifdef VRAM_CLEAR_EN
      r_busy     <= 1'b0;
      r_clr_left <= '0;
`endif
    end else begin
      r_gnt <= '0;
      r_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef VRAM_CLEAR_EN
          if (vblank) begin
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_we       <= 1'b1;
            r_waddr    <= '0;
            r_wdata    <= BG_COLOR;
            r_clr_left <= DW'(NPIX - 1);
          end
`endif
        end
`ifdef VRAM_CLEAR_EN
        S_CLEAR: begin
          if (w_clr_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_we       <= 1'b1;
            r_waddr    <= r_waddr + 1'b1;
            r_clr_left <= r_clr_left - 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
      if (w_do_grant) begin
        r_gnt   <= w_arb_gnt;
        r_rr    <= w_rr_next;
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        if (w_sel_oob) begin
          r_oob <= 1'b1;
        end else begin
          r_we <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.we    = r_we;
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;
  assign oob_err   = r_oob;

endmodule

// File: tb/tb_vram_wr_sched.sv
// tb_vram_wr_sched: randomized scoreboard bench for vram_wr_sched. Clear
// scenarios are included when VRAM_CLEAR_EN is defined.
module tb_vram_wr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 15;
  localparam int HL   = 200;
  localparam int VL   = 150;
  localparam int NPIX = HL * VL;
  localparam logic [11:0] TB_BG = 12'h000;

`ifdef VRAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            we;
    logic [DW-1:0]   waddr;
    logic [11:0]     wdata;
    logic            chk_wa;
    logic            busy;
    logic            oob;
  } exp_t;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic vblank = 1'b0;
  logic busy;
  logic oob_err;

  vram_wr_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  vram_wr_sched #(
    .DW       (DW),
    .H_LEN    (HL),
    .V_LEN    (VL),
    .NREQ     (NREQ),
    .BG_COLOR (TB_BG)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .vblank  (vblank),
    .bus     (bus),
    .busy    (busy),
    .oob_err (oob_err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  int          m_rr;
  int          m_last;
  logic [DW-1:0] m_waddr;
  logic [11:0] m_wdata;
  bit          m_wa_known;
  bit          m_oob;
  bit          m_clr;
  int          m_cpos;

  // client state: 0 idle, 1 waiting for grant, 2 just granted
  int          c_st[NREQ];
  logic [DW-1:0] c_addr[NREQ];
  logic [11:0] c_data[NREQ];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endfunction

  // Expected outputs after the next clock edge, from the written rules
  task automatic model_step(input logic [NREQ-1:0] r, input logic rst, input logic vb);
    exp_t e;
    int   w;
    e = '0;
    w = -1;
    if (!rst) begin
      m_rr = 0; m_waddr = '0; m_wdata = '0; m_wa_known = 1'b1;
      m_oob = 1'b0; m_clr = 1'b0; m_cpos = 0;
    end else if (m_clr && m_cpos < NPIX - 1) begin
      m_cpos++;
      e.we = 1'b1; e.busy = 1'b1;
      m_waddr = DW'(m_cpos); m_wdata = TB_BG; m_wa_known = 1'b1;
    end else if (!m_clr && vb && CLR_EN) begin
      m_clr = 1'b1; m_cpos = 0;
      e.we = 1'b1; e.busy = 1'b1;
      m_waddr = '0; m_wdata = TB_BG; m_wa_known = 1'b1;
    end else begin
      m_clr = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (w < 0 && r[j] && j != m_last) w = j;
      end
      if (w >= 0) begin
        e.gnt[w] = 1'b1;
        m_rr     = (w + 1) % NREQ;
        m_waddr  = c_addr[w];
        m_wdata  = c_data[w];
        if (int'(c_addr[w]) >= NPIX) begin
          m_oob = 1'b1; m_wa_known = 1'b0;
        end else begin
          e.we = 1'b1; m_wa_known = 1'b1;
        end
      end
    end
    m_last   = w;
    e.oob    = m_oob;
    e.waddr  = m_waddr;
    e.wdata  = m_wdata;
    e.chk_wa = m_wa_known;
    q.push_back(e);
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic rst, input logic vb);
    logic [NREQ*DW-1:0] a;
    logic [NREQ*12-1:0] d;
    for (int i = 0; i < NREQ; i++) begin
      a[i*DW +: DW] = c_addr[i];
      d[i*12 +: 12] = c_data[i];
    end
    @(negedge clk);
    rstn = rst; vblank = vb;
    bus.req = r; bus.req_addr = a; bus.req_data = d;
    model_step(r, rst, vb);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("we", 32'(bus.we), 32'(e.we));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("oob_err", 32'(oob_err), 32'(e.oob));
        if (e.chk_wa) begin
          chk("waddr", 32'(bus.waddr), 32'(e.waddr));
          chk("wdata", 32'(bus.wdata), 32'(e.wdata));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] r;
    logic vb;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    m_rr = 0; m_last = -1; m_waddr = '0; m_wdata = '0;
    m_wa_known = 1'b1; m_oob = 1'b0; m_clr = 1'b0; m_cpos = 0;
    for (int i = 0; i < NREQ; i++) begin
      c_st[i]   = 0;
      c_addr[i] = DW'(100 * i + 7);
      c_data[i] = 12'(12'h111 * (i + 1));
    end

    // reset held with every client requesting, then round-robin 0,1,2,3,0
    repeat (3) drive('1, 1'b0, 1'b0);
    repeat (5) drive('1, 1'b1, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);

    // single client 2, then idle cycles where waddr/wdata hold
    c_addr[2] = 15'd123; c_data[2] = 12'hF00;
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);

    // out-of-range address: granted, not written, sticky error
    c_addr[1] = DW'(NPIX);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);

    // randomized clients
    for (int cyc = 0; cyc < 2500; cyc++) begin
      r = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (c_st[i] == 2) begin
          r[i] = 1'($urandom_range(0, 1));
          c_st[i] = 0;
        end else if (c_st[i] == 1) begin
          r[i] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          c_st[i] = 1;
          r[i] = 1'b1;
          if ($urandom_range(0, 9) == 0) c_addr[i] = DW'($urandom_range(NPIX, (1 << DW) - 1));
          else c_addr[i] = DW'($urandom_range(0, NPIX - 1));
          c_data[i] = 12'($urandom);
        end
      end
      vb = CLR_EN ? 1'b0 : ($urandom_range(0, 19) == 0);
      drive(r, 1'b1, vb);
      if (m_last >= 0) c_st[m_last] = 2;
    end

    // reset clears the sticky error
    repeat (2) drive('0, 1'b0, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);

`ifdef VRAM_CLEAR_EN
    // full clear; a request and a second vblank arrive mid-clear
    drive('0, 1'b1, 1'b1);
    for (int k = 0; k < 200 && m_cpos < 100; k++) drive('0, 1'b1, 1'b0);
    c_addr[0] = 15'd55; c_data[0] = 12'h0F0;
    drive(4'b0001, 1'b1, 1'b1);
    for (int k = 0; k < NPIX + 4 && m_clr; k++) drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);

    // reset at clear address 500, then restart from address 0
    drive('0, 1'b1, 1'b1);
    for (int k = 0; k < 600 && m_cpos < 500; k++) drive('0, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b1);
    for (int k = 0; k < NPIX + 4 && m_clr; k++) drive('0, 1'b1, 1'b0);
    repeat (2) drive('0, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
